// File: rtl/calc_pkg.sv
// Shared calculator datapath types and defaults.
package calc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;

   localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared across the calculator datapath.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   assign s_o    = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_wcarry_nbits.sv
// Bit-serial unsigned adder: one full_adder cell, one bit per clock, LSB first.
// Operands are captured on start; sum and carry out are held from done until the next done.
module serial_add_wcarry_nbits
   import calc_pkg::*;
#(
   parameter int unsigned width = DefaultWidth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [width-1:0] s_o,
   output logic             cout_o
);

   // One extra count value so width itself is representable.
   localparam int unsigned CntW = $clog2(width + 1);
   typedef logic [CntW-1:0] cnt_t;

   serial_state_t    state_q, state_d;
   logic [width-1:0] a_sh_q, a_sh_d;
   logic [width-1:0] b_sh_q, b_sh_d;
   logic [width-1:0] s_sh_q, s_sh_d;
   logic [width-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   cnt_t             cnt_q, cnt_d;
   logic             fa_s, fa_c;

   full_adder u_full_adder (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_c)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = RUN;
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               s_sh_d  = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d            = a_sh_q >> 1;
            b_sh_d            = b_sh_q >> 1;
            // Sum bits enter at the MSB so bit 0 lands at position 0 after width shifts.
            s_sh_d            = s_sh_q >> 1;
            s_sh_d[width-1]   = fa_s;
            carry_d           = fa_c;
            cnt_d             = cnt_q + cnt_t'(1);
            if (cnt_q == cnt_t'(width - 1)) begin
               state_d = DONE;
               s_d     = s_sh_d;
               cout_d  = fa_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign s_o    = s_q;
   assign cout_o = cout_q;

endmodule
